mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Sequencer and arbiter for the mainboard's shared 8-bit external memory bus. Accepts 16-bit instruction fetches from the PC path and byte load/store requests from the datapath, arbitrates between them, and decodes the address into PROM, RAM or flash. It drives address, data, `promOE_`/`ramOE_`/`flashOE_`/`ramWE_` with setup/strobe/hold timing sized for 54 ns parts. Sits between `mainboard` and the memory cards and replaces the direct `dataBus` hookup.

## Interface
- `WAIT_CYC`, 3, clock cycles strobe is held low (≥1)
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `fetch_req` in 1 instruction fetch request, held until `fetch_ack`
- `fetch_addr` in 16 byte address of instruction; bit 0 ignored (treated 0)
- `fetch_ack` out 1 one-cycle pulse, `fetch_data` valid
- `fetch_data` out 16 {byte@addr, byte@addr+1}
- `dreq` in 1 data request, held with `dwe`/`daddr`/`dwdata` stable until `dack`
- `dwe` in 1 1 = store, 0 = load
- `daddr` in 16 data byte address
- `dwdata` in 8 store data
- `dack` out 1 one-cycle pulse completing data request
- `drdata` out 8 load data, valid with `dack`
- `derr` out 1 with `dack`: store to non-RAM region, no bus cycle run
- `mem_addr` out 16 bus address
- `mem_dout` out 8 bus write data
- `mem_doe` out 1 bus drive enable (store cycles only)
- `mem_din` in 8 bus read data
- `promOE_`, `ramOE_`, `flashOE_`, `ramWE_` out 1 each, active-low strobes

## Operation
- Address map: 0x0000–0x7FFF PROM, 0x8000–0xBFFF RAM, 0xC000–0xFFFF flash. Loads and fetches are allowed in all regions; stores are allowed in RAM only.
- States: IDLE, SETUP, STROBE, HOLD, ERR.
- Requests are sampled only in IDLE. `dreq` has priority over `fetch_req`. The grant is latched, and a two-byte fetch is never preempted.
- IDLE→ERR on a store to PROM or flash. ERR asserts `dack`=`derr`=1 for one cycle, then returns to IDLE. No strobe fires.
- IDLE→SETUP on a grant.
  - SETUP: `mem_addr` is driven, all strobes high.
  - STROBE: the region's OE_ is low (loads/fetches), or `ramWE_` is low (stores). It lasts exactly `WAIT_CYC` cycles, timed by a down-counter.
  - HOLD: strobes high, address and write data unchanged.
- `mem_din` is registered on the clock edge that leaves STROBE.
- Fetch: byte 0 at addr goes to `fetch_data[15:8]`. HOLD then returns to SETUP with address |1, and byte 1 goes to `fetch_data[7:0]`.
- Ack (`fetch_ack` or `dack`) is asserted during the final HOLD. The next state is IDLE.
- `mem_doe` = 1 and `mem_dout` = `dwdata` in SETUP, STROBE and HOLD of a store. Otherwise `mem_doe` = 0.
- At most one strobe is low in any cycle; `ramOE_` and `ramWE_` are never low together.
- Reset values: state IDLE; all strobes 1; `mem_doe` 0; acks and `derr` 0; `mem_addr`, `mem_dout`, `fetch_data`, `drdata` all 0.
- Reset mid-transaction: strobes deassert immediately (asynchronous), the transaction is dropped, and no ack is issued. Requesters re-issue after reset.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Data transaction: request sampled at edge N; SETUP in cycle N+1; STROBE in cycles N+2..N+1+W; HOLD/ack in cycle N+2+W. With W=3, ack arrives 5 cycles after sampling.
- Fetch: ack at N+2(W+2). With W=3, that is 10 cycles.
- Store error: ack at N+1.
- At least one IDLE cycle separates transactions.
- Simultaneous `dreq` and `fetch_req` in IDLE: data is served first, the fetch starts after the next IDLE.
- Counter width is $clog2(WAIT_CYC+1). W=1 is legal and gives a one-cycle strobe.

## Structure
- `mem_bus_pkg` holds:
  - the state enum;
  - the region enum (PROM/RAM/FLASH);
  - map base constants;
  - a `region_of(addr)` function;
  - a `store_ok(region)` function.
- One sub-module, `mem_region_decode`: purely combinational, address → region plus one-hot OE_ select. The FSM registers its output.

## Test plan
- Reset with both requests high: all strobes stay 1 and there are no acks. Release reset: the data request is served first.
- Load at 0x8005 with `mem_din`=0xA5, W=3: `ramOE_` low for 3 cycles, then `dack` with `drdata`=0xA5 5 cycles after sampling.
- Fetch at 0x0011: bytes are read at 0x0010 then 0x0011 with `mem_din` 0x12, 0x34. `fetch_data`=0x1234 and `fetch_ack` arrive 10 cycles after sampling. `dreq` raised mid-fetch waits.
- Store 0x5A to 0xC000: `dack`+`derr` the next cycle, no strobe, `mem_doe` stays 0.
- Store 0x5A to 0xBFFF: `ramWE_` low for W cycles with `mem_dout`=0x5A, and `mem_doe` high SETUP through HOLD. `derr`=0.
- Assert `rst_n`=0 during STROBE of a load: OE_ goes high within the same cycle, no `dack`. The first request after reset completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the external 8-bit memory bus sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    RGN_PROM,
    RGN_RAM,
    RGN_FLASH
  } region_t;

  // PROM starts at 0x0000 and runs up to RAM_BASE-1.
  localparam logic [15:0] RAM_BASE   = 16'h8000;
  localparam logic [15:0] FLASH_BASE = 16'hC000;

  function automatic region_t region_of(input logic [15:0] addr);
    if (addr >= FLASH_BASE) begin
      return RGN_FLASH;
    end else if (addr >= RAM_BASE) begin
      return RGN_RAM;
    end else begin
      return RGN_PROM;
    end
  endfunction

  // Only RAM is writable; PROM and flash stores are rejected without a bus cycle.
  function automatic logic store_ok(input region_t region);
    return (region == RGN_RAM);
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Address decoder: maps a bus address to its region and a one-hot output-enable select.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
// Ports: i_addr (16b byte address) -> o_region (region_t), o_oe_sel ({flash, ram, prom}, one-hot).
module mem_region_decode
  import mem_bus_pkg::*;
(
  input  logic [15:0] i_addr,
  output region_t     o_region,
  output logic [2:0]  o_oe_sel
);

  always_comb begin
    o_region = region_of(i_addr);
    case (o_region)
      RGN_PROM: o_oe_sel = 3'b001;
      RGN_RAM:  o_oe_sel = 3'b010;
      default:  o_oe_sel = 3'b100;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Arbiter/sequencer for the shared 8-bit memory bus: data load/store vs 16-bit instruction fetch.
// Latency: data ack W+2 cycles after sampling, fetch ack 2(W+2), rejected store ack after 1 cycle.
// Backpressure: requesters hold their request until the one-cycle ack; requests sampled only in IDLE.
// Ports: fetch_req/addr -> fetch_ack/data; dreq/dwe/daddr/dwdata -> dack/drdata/derr;
//        bus side mem_addr/mem_dout/mem_doe/mem_din plus active-low strobes promOE_/ramOE_/flashOE_/ramWE_.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [15:0] fetch_data,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [15:0] daddr,
  input  logic [7:0]  dwdata,
  output logic        dack,
  output logic [7:0]  drdata,
  output logic        derr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_doe,
  input  logic [7:0]  mem_din,
  output logic        promOE_,
  output logic        ramOE_,
  output logic        flashOE_,
  output logic        ramWE_
);

  localparam int CW = $clog2(WAIT_CYC + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_fetch;
  logic          r_second;
  logic          r_we;
  logic [2:0]    r_oe_sel;
  logic [15:0]   r_mem_addr;
  logic [7:0]    r_mem_dout;
  logic          r_mem_doe;
  logic          r_prom_oe_n;
  logic          r_ram_oe_n;
  logic          r_flash_oe_n;
  logic          r_ram_we_n;
  logic          r_fetch_ack;
  logic [15:0]   r_fetch_data;
  logic          r_dack;
  logic          r_derr;
  logic [7:0]    r_drdata;

  logic [15:0]   w_fetch_addr;
  logic [15:0]   w_req_addr;
  region_t       w_region;
  logic [2:0]    w_oe_sel;

  // Fetches are always word-aligned; the low byte address comes from HOLD -> SETUP.
  assign w_fetch_addr = fetch_addr & 16'hFFFE;
  // Data has priority, so decode whichever address would win the grant.
  assign w_req_addr   = dreq ? daddr : w_fetch_addr;

  mem_region_decode u_decode (
    .i_addr   (w_req_addr),
    .o_region (w_region),
    .o_oe_sel (w_oe_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_is_fetch   <= 1'b0;
      r_second     <= 1'b0;
      r_we         <= 1'b0;
      r_oe_sel     <= 3'b000;
      r_mem_addr   <= 16'h0000;
      r_mem_dout   <= 8'h00;
      r_mem_doe    <= 1'b0;
      r_prom_oe_n  <= 1'b1;
      r_ram_oe_n   <= 1'b1;
      r_flash_oe_n <= 1'b1;
      r_ram_we_n   <= 1'b1;
      r_fetch_ack  <= 1'b0;
      r_fetch_data <= 16'h0000;
      r_dack       <= 1'b0;
      r_derr       <= 1'b0;
      r_drdata     <= 8'h00;
    end else begin
      r_fetch_ack <= 1'b0;
      r_dack      <= 1'b0;
      r_derr      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dreq) begin
            if (dwe && !store_ok(w_region)) begin
              r_state <= ST_ERR;
              r_dack  <= 1'b1;
              r_derr  <= 1'b1;
            end else begin
              r_state    <= ST_SETUP;
              r_is_fetch <= 1'b0;
              r_second   <= 1'b0;
              r_we       <= dwe;
              r_oe_sel   <= w_oe_sel;
              r_mem_addr <= daddr;
              r_mem_dout <= dwdata;
              r_mem_doe  <= dwe;
            end
          end else if (fetch_req) begin
            r_state    <= ST_SETUP;
            r_is_fetch <= 1'b1;
            r_second   <= 1'b0;
            r_we       <= 1'b0;
            r_oe_sel   <= w_oe_sel;
            r_mem_addr <= w_fetch_addr;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_cnt   <= CW'(WAIT_CYC);
          if (r_we) begin
            r_ram_we_n <= 1'b0;
          end else begin
            r_prom_oe_n  <= ~r_oe_sel[0];
            r_ram_oe_n   <= ~r_oe_sel[1];
            r_flash_oe_n <= ~r_oe_sel[2];
          end
        end
        ST_STROBE: begin
          if (r_cnt == CW'(1)) begin
            r_state      <= ST_HOLD;
            r_prom_oe_n  <= 1'b1;
            r_ram_oe_n   <= 1'b1;
            r_flash_oe_n <= 1'b1;
            r_ram_we_n   <= 1'b1;
            if (r_is_fetch) begin
              if (r_second) begin
                r_fetch_data[7:0] <= mem_din;
                r_fetch_ack       <= 1'b1;
              end else begin
                r_fetch_data[15:8] <= mem_din;
              end
            end else begin
              r_dack <= 1'b1;
              if (!r_we) begin
                r_drdata <= mem_din;
              end
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          // First half of a fetch loops back for the odd byte; the grant stays latched.
          if (r_is_fetch && !r_second) begin
            r_state       <= ST_SETUP;
            r_second      <= 1'b1;
            r_mem_addr[0] <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_mem_doe <= 1'b0;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fetch_ack  = r_fetch_ack;
  assign fetch_data = r_fetch_data;
  assign dack       = r_dack;
  assign drdata     = r_drdata;
  assign derr       = r_derr;
  assign mem_addr   = r_mem_addr;
  assign mem_dout   = r_mem_dout;
  assign mem_doe    = r_mem_doe;
  assign promOE_    = r_prom_oe_n;
  assign ramOE_     = r_ram_oe_n;
  assign flashOE_   = r_flash_oe_n;
  assign ramWE_     = r_ram_we_n;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with WAIT_CYC=3.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Strobe vector order: {promOE_, ramOE_, flashOE_, ramWE_}.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic        dreq;
  logic        dwe;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dack;
  logic [7:0]  drdata;
  logic        derr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_doe;
  logic [7:0]  mem_din;
  logic        promOE_;
  logic        ramOE_;
  logic        flashOE_;
  logic        ramWE_;
  logic [3:0]  strb;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [3:0] S_NONE = 4'b1111;
  localparam logic [3:0] S_PROM = 4'b0111;
  localparam logic [3:0] S_RAMR = 4'b1011;
  localparam logic [3:0] S_RAMW = 4'b1110;

  always #5 clk = ~clk;

  assign strb = {promOE_, ramOE_, flashOE_, ramWE_};

  mem_bus_ctrl #(.WAIT_CYC(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .dreq       (dreq),
    .dwe        (dwe),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .dack       (dack),
    .drdata     (drdata),
    .derr       (derr),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_doe    (mem_doe),
    .mem_din    (mem_din),
    .promOE_    (promOE_),
    .ramOE_     (ramOE_),
    .flashOE_   (flashOE_),
    .ramWE_     (ramWE_)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h0011;
    dreq       = 1'b1;
    dwe        = 1'b0;
    daddr      = 16'h8005;
    dwdata     = 8'h00;
    mem_din    = 8'hA5;

    // Reset held with both requests high: nothing moves.
    repeat (3) cyc();
    chk("rst_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("rst_dack", {15'h0, dack}, 16'h0);
    chk("rst_fack", {15'h0, fetch_ack}, 16'h0);
    chk("rst_derr", {15'h0, derr}, 16'h0);
    chk("rst_doe", {15'h0, mem_doe}, 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_dout", {8'h0, mem_dout}, 16'h0);
    chk("rst_fdata", fetch_data, 16'h0000);
    chk("rst_drdata", {8'h0, drdata}, 16'h0);

    // Release: data load at 0x8005 wins over the pending fetch.
    rst_n = 1'b1;
    cyc();  // N+1 SETUP
    chk("ld_setup_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("ld_setup_addr", mem_addr, 16'h8005);
    for (int i = 0; i < 3; i++) begin
      cyc();  // N+2..N+4 STROBE
      chk("ld_strobe_strb", {12'h0, strb}, {12'h0, S_RAMR});
      chk("ld_strobe_dack", {15'h0, dack}, 16'h0);
      chk("ld_strobe_doe", {15'h0, mem_doe}, 16'h0);
    end
    cyc();  // N+5 HOLD + ack
    chk("ld_hold_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("ld_dack", {15'h0, dack}, 16'h1);
    chk("ld_drdata", {8'h0, drdata}, 16'h00A5);
    chk("ld_derr", {15'h0, derr}, 16'h0);
    chk("ld_fack", {15'h0, fetch_ack}, 16'h0);
    dreq    = 1'b0;
    mem_din = 8'h12;

    // Fetch at 0x0011 starts after the next IDLE cycle.
    cyc();  // IDLE
    chk("idle_dack", {15'h0, dack}, 16'h0);
    chk("idle_strb", {12'h0, strb}, {12'h0, S_NONE});
    cyc();  // N'+1 SETUP
    chk("f0_setup_addr", mem_addr, 16'h0010);
    chk("f0_setup_strb", {12'h0, strb}, {12'h0, S_NONE});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f0_strobe_strb", {12'h0, strb}, {12'h0, S_PROM});
    end
    cyc();  // N'+5 HOLD (first byte)
    chk("f0_hold_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("f0_hold_fack", {15'h0, fetch_ack}, 16'h0);
    chk("f0_hold_addr", mem_addr, 16'h0010);
    cyc();  // N'+6 SETUP (second byte); data request raised mid-fetch
    chk("f1_setup_addr", mem_addr, 16'h0011);
    chk("f1_setup_strb", {12'h0, strb}, {12'h0, S_NONE});
    mem_din = 8'h34;
    dreq    = 1'b1;
    dwe     = 1'b0;
    daddr   = 16'h8005;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f1_strobe_strb", {12'h0, strb}, {12'h0, S_PROM});
      chk("f1_strobe_dack", {15'h0, dack}, 16'h0);
    end
    cyc();  // N'+10 final HOLD + ack
    chk("f_fack", {15'h0, fetch_ack}, 16'h1);
    chk("f_fdata", fetch_data, 16'h1234);
    chk("f_dack", {15'h0, dack}, 16'h0);
    chk("f_strb", {12'h0, strb}, {12'h0, S_NONE});
    fetch_req = 1'b0;
    mem_din   = 8'h3C;

    // The waiting load now runs.
    cyc();  // IDLE
    chk("idle2_fack", {15'h0, fetch_ack}, 16'h0);
    repeat (4) cyc();
    chk("wait_ld_dack_early", {15'h0, dack}, 16'h0);
    cyc();
    chk("wait_ld_dack", {15'h0, dack}, 16'h1);
    chk("wait_ld_drdata", {8'h0, drdata}, 16'h003C);
    dreq = 1'b0;
    cyc();  // IDLE

    // Store to flash: rejected next cycle, no bus activity.
    dreq   = 1'b1;
    dwe    = 1'b1;
    daddr  = 16'hC000;
    dwdata = 8'h5A;
    cyc();
    chk("serr_dack", {15'h0, dack}, 16'h1);
    chk("serr_derr", {15'h0, derr}, 16'h1);
    chk("serr_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("serr_doe", {15'h0, mem_doe}, 16'h0);
    dreq = 1'b0;
    cyc();  // IDLE
    chk("serr_post_dack", {15'h0, dack}, 16'h0);
    chk("serr_post_derr", {15'h0, derr}, 16'h0);
    chk("serr_post_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("serr_post_doe", {15'h0, mem_doe}, 16'h0);

    // Store to the last RAM byte.
    dreq   = 1'b1;
    dwe    = 1'b1;
    daddr  = 16'hBFFF;
    dwdata = 8'h5A;
    cyc();  // SETUP
    chk("st_setup_doe", {15'h0, mem_doe}, 16'h1);
    chk("st_setup_dout", {8'h0, mem_dout}, 16'h005A);
    chk("st_setup_addr", mem_addr, 16'hBFFF);
    chk("st_setup_strb", {12'h0, strb}, {12'h0, S_NONE});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_strobe_strb", {12'h0, strb}, {12'h0, S_RAMW});
      chk("st_strobe_doe", {15'h0, mem_doe}, 16'h1);
      chk("st_strobe_dout", {8'h0, mem_dout}, 16'h005A);
    end
    cyc();  // HOLD + ack
    chk("st_hold_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("st_hold_doe", {15'h0, mem_doe}, 16'h1);
    chk("st_dack", {15'h0, dack}, 16'h1);
    chk("st_derr", {15'h0, derr}, 16'h0);
    dreq = 1'b0;
    dwe  = 1'b0;
    cyc();  // IDLE
    chk("st_post_doe", {15'h0, mem_doe}, 16'h0);
    chk("st_post_dack", {15'h0, dack}, 16'h0);

    // Reset during the strobe of a PROM load.
    dreq    = 1'b1;
    daddr   = 16'h0100;
    mem_din = 8'h99;
    cyc();  // SETUP
    cyc();  // STROBE 1
    chk("rl_strobe_strb", {12'h0, strb}, {12'h0, S_PROM});
    rst_n = 1'b0;
    dreq  = 1'b0;
    #1;
    chk("rl_async_strb", {12'h0, strb}, {12'h0, S_NONE});
    chk("rl_async_drdata", {8'h0, drdata}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rl_no_dack", {15'h0, dack}, 16'h0);
    end
    rst_n = 1'b1;
    cyc();
    chk("rl_idle_dack", {15'h0, dack}, 16'h0);
    chk("rl_idle_strb", {12'h0, strb}, {12'h0, S_NONE});

    // First request after reset completes normally.
    dreq    = 1'b1;
    daddr   = 16'h8005;
    mem_din = 8'h77;
    repeat (4) cyc();
    chk("rl_after_dack_early", {15'h0, dack}, 16'h0);
    cyc();
    chk("rl_after_dack", {15'h0, dack}, 16'h1);
    chk("rl_after_drdata", {8'h0, drdata}, 16'h0077);
    dreq = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
